// File: rtl/spi_tx_engine.sv
// spi_tx_engine: SPI master transmit path, made of an sclk/baud generator and a byte shift transmitter.
// Build option: define SPI_TX_LSBF_EN to honour the lsbf port. Otherwise every frame goes out MSB first.
//
// state | meaning
// IDLE  | no frame in flight; ready_o follows en
// SHIFT | frame in flight; bits advance on sample/shift strobes
module spi_tx_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              sclk_en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [2:0]        spr,
  input  logic [2:0]        sppr,
  input  logic              en,
  input  logic              lsbf,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              sclk,
  output logic              sample,
  output logic              sdo
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [9:0]         cnt;
  logic               phase;
  logic               shift;
  logic [10:0]        half;
  logic [9:0]         half_m1;
  logic               wrap;
  logic               lsbf_in;
  logic               lsbf_q;
  logic [DATA_W-1:0]  data_q;
  logic [IDX_W-1:0]   bit_cnt;

`ifdef SPI_TX_LSBF_EN
  assign lsbf_in = lsbf;
`else
  logic unused_lsbf;
  assign unused_lsbf = lsbf;
  assign lsbf_in     = 1'b0;
`endif

  // Half period spans 1..1024 clocks, so it needs 11 bits; its terminal count fits in 10.
  assign half    = {7'd0, ({1'b0, sppr} + 4'd1)} << spr;
  assign half_m1 = 10'(half - 11'd1);
  assign wrap    = (cnt == half_m1);
  assign sclk    = phase ^ cpol;

  function automatic logic bit_at(input logic [DATA_W-1:0] d,
                                  input logic              lsb,
                                  input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] ridx;
    ridx = IDX_W'(DATA_W - 1) - idx;
    return lsb ? d[idx] : d[ridx];
  endfunction

  // A leading edge is phase 0->1. cpha decides whether that edge samples or shifts.
  always_ff @(posedge clk_i) begin
    if (!rst_n || !sclk_en) begin
      cnt    <= '0;
      phase  <= 1'b0;
      sample <= 1'b0;
      shift  <= 1'b0;
    end else begin
      sample <= 1'b0;
      shift  <= 1'b0;
      if (wrap) begin
        cnt   <= '0;
        phase <= ~phase;
        if (phase ^ cpha) shift  <= 1'b1;
        else              sample <= 1'b1;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_o <= 1'b0;
      sdo     <= 1'b0;
      bit_cnt <= '0;
      data_q  <= '0;
      lsbf_q  <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            data_q  <= data_i;
            lsbf_q  <= lsbf_in;
            bit_cnt <= '0;
            sdo     <= bit_at(data_i, lsbf_in, IDX_W'(0));
            state   <= SHIFT;
            ready_o <= 1'b0;
          end else begin
            ready_o <= 1'b1;
          end
        end
        SHIFT: begin
          ready_o <= 1'b0;
          if (sample) begin
            // ready_o stays low for the first IDLE cycle, which enforces the inter-byte gap.
            if (bit_cnt == IDX_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift && bit_cnt != '0) begin
            sdo <= bit_at(data_q, lsbf_q, bit_cnt);
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_engine.sv
// Self-checking bench for spi_tx_engine. It uses a vector table, hand-written corner sequences, and random frames.
// Expected bit order and timing come from the bit-order and half-period rules, computed with plain arithmetic.
module tb_spi_tx_engine;
  logic       clk_i = 1'b0;
  logic       rst_n, sclk_en, cpol, cpha, en, lsbf, valid_i;
  logic [2:0] spr, sppr;
  logic [7:0] data_i;
  logic       ready_o, sclk, sample, sdo;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SPI_TX_LSBF_EN
  localparam bit LSBF_ON = 1'b1;
`else
  localparam bit LSBF_ON = 1'b0;
`endif

  spi_tx_engine #(.DATA_W(8)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .sclk_en(sclk_en), .cpol(cpol), .cpha(cpha),
    .spr(spr), .sppr(sppr), .en(en), .lsbf(lsbf), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .sclk(sclk), .sample(sample), .sdo(sdo)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbf;
    logic [2:0] spr;
    logic [2:0] sppr;
    logic [7:0] data;
    int         half;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  task automatic run_frame(input string name, input logic c_pol, input logic c_pha,
                           input logic l_sbf, input logic [2:0] s_pr, input logic [2:0] s_ppr,
                           input logic [7:0] d, input int h, input logic [7:0] exp_seq,
                           input bit noise);
    logic [7:0] got;
    int         nsamp, cyc, last_t, ready_at;
    bit         space_ok, level_ok, hold_ok;
    logic       last_bit, exp_lvl;
    sclk_en = 1'b0;
    cpol = c_pol; cpha = c_pha; lsbf = l_sbf; spr = s_pr; sppr = s_ppr;
    tick();
    check($sformatf("%s_park", name), {30'd0, sclk, sample}, {30'd0, c_pol, 1'b0});
    sclk_en = 1'b1;
    cyc = 0;
    while (!ready_o && cyc < 20) begin tick(); cyc++; end
    check($sformatf("%s_ready_wait", name), ready_o, 1);
    data_i = d; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; data_i = 8'($urandom);
    check($sformatf("%s_ready_drop", name), ready_o, 0);
    exp_lvl  = c_pol ^ ~c_pha;
    got = '0; nsamp = 0; cyc = 0; last_t = 0; space_ok = 1; level_ok = 1;
    while (nsamp < 8 && cyc < 40 * h + 100) begin
      if (sample) begin
        got = {got[6:0], sdo};
        if (sclk !== exp_lvl) level_ok = 0;
        if (nsamp > 0 && (cyc - last_t) != 2 * h) space_ok = 0;
        last_t = cyc;
        nsamp++;
      end
      if (nsamp < 8) begin
        if (noise) begin valid_i = 1'($urandom); data_i = 8'($urandom); end
        tick();
        cyc++;
      end
    end
    valid_i = 1'b0;
    check($sformatf("%s_samples", name), nsamp, 8);
    check($sformatf("%s_seq", name), got, exp_seq);
    check($sformatf("%s_level", name), level_ok, 1);
    check($sformatf("%s_spacing", name), space_ok, 1);
    check($sformatf("%s_ready_last", name), ready_o, 0);
    last_bit = got[0]; hold_ok = 1; ready_at = -1;
    for (int i = 1; i <= 2 * h + 4; i++) begin
      tick();
      if (sdo !== last_bit) hold_ok = 0;
      if (ready_at < 0 && ready_o === 1'b1) ready_at = i;
    end
    check($sformatf("%s_ready_back", name), (ready_at >= 1 && ready_at <= 3) ? 1 : 0, 1);
    check($sformatf("%s_sdo_hold", name), hold_ok, 1);
  endtask

  initial begin
    int         prev, changes, samples, cyc, hi, lo, nsamp, h;
    logic       hold, ok, r_pol, r_pha, r_lsb;
    logic [2:0] r_spr, r_sppr;
    logic [7:0] d, seq, exp;
    bit         b;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hC1, 1, 8'h83, 8'hC1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hC1, 1, 8'h83, 8'hC1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'hC1, 1, 8'h83, 8'hC1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd1, 8'h96, 8, 8'h69, 8'h96};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 8'hA7, 6, 8'hE5, 8'hA7};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 8'h01, 4, 8'h80, 8'h01};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 8'hC1, 1, 8'h83, 8'hC1};

    rst_n = 1'b0; cpol = 1'b1; cpha = 1'b0; en = 1'b1; sclk_en = 1'b1; lsbf = 1'b0;
    spr = 3'd0; sppr = 3'd0; valid_i = 1'b0; data_i = 8'h00;
    repeat (3) tick();
    check("rst_sclk", sclk, 1);
    check("rst_ready", ready_o, 0);
    check("rst_sdo", sdo, 0);
    check("rst_sample", sample, 0);
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", ready_o, 1);

    // Fastest rate: sclk toggles on every clock, with one sample per 2-clock period.
    sclk_en = 1'b0; cpol = 1'b0; cpha = 1'b0; spr = 3'd0; sppr = 3'd0;
    tick();
    sclk_en = 1'b1;
    prev = sclk; changes = 0; samples = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (sclk != prev) changes++;
      prev = sclk;
      if (sample) samples++;
    end
    check("fast_toggles", changes, 16);
    check("fast_samples", samples, 8);

    // H = 8: sclk stays high for 8 clocks, then low for 8 clocks.
    sclk_en = 1'b0; spr = 3'd2; sppr = 3'd1;
    tick();
    sclk_en = 1'b1;
    cyc = 0;
    while (sclk !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    hi = 0;
    while (sclk === 1'b1 && hi < 40) begin hi++; tick(); end
    lo = 0;
    while (sclk === 1'b0 && lo < 40) begin lo++; tick(); end
    check("h8_high", hi, 8);
    check("h8_low", lo, 8);

    foreach (tbl[i]) begin
      exp = (tbl[i].lsbf && LSBF_ON) ? tbl[i].exp_lsb : tbl[i].exp_msb;
      run_frame($sformatf("vec%0d", i), tbl[i].cpol, tbl[i].cpha, tbl[i].lsbf, tbl[i].spr,
                tbl[i].sppr, tbl[i].data, tbl[i].half, exp, 1'b0);
    end

    // Drop en after the 3rd sample: the frame aborts and sdo freezes on bit 2 of 0xC1, MSB first.
    sclk_en = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbf = 1'b0; spr = 3'd0; sppr = 3'd1;
    tick();
    sclk_en = 1'b1;
    cyc = 0;
    while (!ready_o && cyc < 20) begin tick(); cyc++; end
    data_i = 8'hC1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    nsamp = 0; cyc = 0;
    while (nsamp < 3 && cyc < 200) begin
      if (sample) nsamp++;
      if (nsamp < 3) begin tick(); cyc++; end
    end
    check("abort_samples", nsamp, 3);
    en = 1'b0;
    tick();
    check("abort_ready", ready_o, 0);
    check("abort_sdo", sdo, 0);
    hold = sdo; ok = 1'b1; valid_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sdo !== hold || ready_o !== 1'b0) ok = 1'b0;
    end
    check("abort_hold", ok, 1);
    valid_i = 1'b0; en = 1'b1;
    tick();
    check("abort_ready_back", ready_o, 1);

    for (int r = 0; r < 20; r++) begin
      r_pol  = 1'($urandom);
      r_pha  = 1'($urandom);
      r_lsb  = 1'($urandom);
      r_spr  = 3'($urandom_range(0, 3));
      r_sppr = 3'($urandom_range(0, 3));
      d      = 8'($urandom);
      h      = (int'(r_sppr) + 1) * (2 ** int'(r_spr));
      seq    = '0;
      for (int k = 0; k < 8; k++) begin
        b   = (r_lsb && LSBF_ON) ? d[k] : d[7-k];
        seq = {seq[6:0], b};
      end
      run_frame($sformatf("rnd%0d", r), r_pol, r_pha, r_lsb, r_spr, r_sppr, d, h, seq, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
